fpnew_value_encoder: RTL and testbench
======================================

// Module: fpnew_value_encoder
// PURPOSE
//  Output-side counterpart to operand classification: rounds an unpacked FP result
//  (sign, biased exp, mantissa + round/sticky, special-class flags) and packs it into IEEE format.
//  Applies canonical NaN, inf/max-finite saturation and NaN-boxing to FLEN, and emits IEEE status.
//  Pipelined, valid/ready handshake; sits at the tail of every FPnew operation-group slice.
// PARAMETERS
//  FpFormat     fp_format_e FP32  target format; WIDTH/EXP_BITS/MAN_BITS derived via fpnew_pkg
//  Width        64                output width (FLEN); bits above WIDTH are NaN-boxed with '1
//  NumPipeRegs  1                 register stages, 0..3; 0 = purely combinational path
//  TagWidth     4                 opaque tag carried alongside each operation
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               synchronous, active-high reset
//  flush_i      in   1               drop all in-flight operations
//  in_valid_i   in   1               input handshake valid
//  in_ready_o   out  1               input handshake ready
//  sign_i       in   1               result sign
//  exp_i        in   EXP_BITS+1      biased exponent, unsigned; 0 = subnormal range (mantissa pre-aligned)
//  mant_i       in   MAN_BITS+1      mantissa incl. implicit bit
//  round_i      in   1               first bit below LSB
//  sticky_i     in   1               OR of all lower bits
//  is_nan_i     in   1               force canonical NaN
//  is_inf_i     in   1               force infinity (signed)
//  is_zero_i    in   1               force signed zero
//  nv_i         in   1               invalid flag from the datapath, passed through
//  dz_i         in   1               divide-by-zero flag, passed through
//  rnd_mode_i   in   roundmode_e     RNE/RTZ/RDN/RUP/RMM
//  tag_i        in   TagWidth        tag
//  out_valid_o  out  1               output handshake valid
//  out_ready_i  in   1               output handshake ready
//  result_o     out  Width           packed, NaN-boxed result
//  status_o     out  status_t        {NV,DZ,OF,UF,NX}
//  tag_o        out  TagWidth        tag of result_o
// BEHAVIOUR
//  - Reset: all stage valids 0 -> out_valid_o=0; data regs, result_o, status_o, tag_o = 0; in_ready_o=1 the cycle after reset.
//  - Stage i accepts when its valid==0 or downstream ready; in_ready_o = stage0 ready (combinational).
//  - Latency NumPipeRegs cycles; full throughput of 1/cycle under out_ready_i=1; order preserved.
//  - Rounding is combinational before stage 0. Increment is decided by rnd_mode_i:
//      RNE: round&(sticky|lsb). RMM: round. RUP: (round|sticky)&!sign. RDN: (round|sticky)&sign. RTZ: 0.
//  - Carry out of the mantissa increments the exponent; a subnormal that rounds to implicit=1 becomes exp=1.
//  - Overflow when post-round exp >= 2^EXP_BITS-1: result is inf, except max-finite for RTZ,
//    for RDN with +, and for RUP with -. Sets OF|NX.
//  - NX = round|sticky|OF. UF = tiny before rounding (exp_i==0) & NX.
//  - Priority is is_nan_i > is_inf_i > is_zero_i > rounding. NaN -> canonical quiet
//    (sign 0, exp '1, mant MSB=1, rest 0), OF/UF/NX=0. Inf/zero carry sign_i and raise no OF/UF/NX.
//  - NV/DZ pass through unchanged in all cases.
//  - NaN-boxing: result_o[Width-1:WIDTH] = '1 always (also for zero/inf).
//  - flush_i: every stage valid cleared the next cycle. An input offered in the same cycle as
//    flush is dropped; in_ready_o stays as computed.
//  - rst_i mid-operation behaves as flush and additionally zeroes the data regs.
//  - NumPipeRegs=0: out_valid_o=in_valid_i, in_ready_o=out_ready_i; flush has no effect.
// STRUCTURE
//  - Use fpnew_pkg for fp_format_e, roundmode_e, status_t, fp_width/exp_bits/man_bits.
//    Add there a function canonical_nan(fmt) returning the pattern above.
//  - Sub-module fpnew_round_pack, combinational: rounding, overflow select, packing, status.
//  - Top level holds the generate-loop pipeline: valid/ready chain plus flush.
// TESTING (FP32, Width=64, NumPipeRegs=1, RNE unless noted)
//  1. exp=127, mant=0x800000, round=0, sticky=0 -> result 0xFFFFFFFF_3F800000, status 0, valid after 1 cycle.
//  2. exp=127, mant=0xFFFFFF, round=1 -> 0xFFFFFFFF_40000000 (carry into exp), NX.
//  3. exp=254, mant=0xFFFFFF, round=1 -> 0x..._7F800000, OF|NX; same with RTZ -> 0x..._7F7FFFFF.
//  4. is_nan_i=1, nv_i=1, sign=1 -> 0xFFFFFFFF_7FC00000, status NV only.
//  5. exp=0, mant=0x000001, round=1, sticky=1 -> 0x..._00000002, UF|NX.
//     exp=0, mant=0x7FFFFF, round=1 -> 0x..._00800000, UF|NX.
//  6. NumPipeRegs=2, out_ready_i=0 for 4 cycles, 3 back-to-back inputs:
//     in_ready_o drops after 2 accepts; all 3 emerge in order.
//     flush_i mid-stream -> out_valid_o=0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FP types and format helpers for the FPnew tail stages.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam int unsigned MAX_FP_WIDTH = 64;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Quiet NaN with sign 0: exponent all ones plus the mantissa MSB, right-aligned.
  function automatic logic [MAX_FP_WIDTH-1:0] canonical_nan(fp_format_e fmt);
    logic [MAX_FP_WIDTH-1:0] ones;
    ones = (MAX_FP_WIDTH'(1) << (exp_bits(fmt) + 1)) - MAX_FP_WIDTH'(1);
    return ones << (man_bits(fmt) - 1);
  endfunction

endpackage

// File: rtl/fpnew_round_pack.sv
// Combinational rounding, overflow saturation, special-value override, packing and
// NaN-boxing of one unpacked FP result.
module fpnew_round_pack import fpnew_pkg::*; #(
  parameter fp_format_e  FpFormat = FP32,
  parameter int unsigned Width    = 64,
  localparam int unsigned EXP_BITS = exp_bits(FpFormat),
  localparam int unsigned MAN_BITS = man_bits(FpFormat)
) (
  input  logic                sign_i,
  input  logic [EXP_BITS:0]   exp_i,
  input  logic [MAN_BITS:0]   mant_i,
  input  logic                round_i,
  input  logic                sticky_i,
  input  logic                is_nan_i,
  input  logic                is_inf_i,
  input  logic                is_zero_i,
  input  logic                nv_i,
  input  logic                dz_i,
  input  roundmode_e          rnd_mode_i,
  output logic [Width-1:0]    result_o,
  output status_t             status_o
);

  localparam int unsigned WIDTH = fp_width(FpFormat);
  localparam logic [MAX_FP_WIDTH-1:0] CNAN = canonical_nan(FpFormat);
  localparam logic [EXP_BITS+1:0] EXP_OVF = {2'b00, {EXP_BITS{1'b1}}};

  function automatic logic round_up(input roundmode_e rm, input logic sign,
                                    input logic lsb, input logic rnd, input logic sticky);
    case (rm)
      RNE:     return rnd & (sticky | lsb);
      RDN:     return (rnd | sticky) & sign;
      RUP:     return (rnd | sticky) & ~sign;
      RMM:     return rnd;
      default: return 1'b0;
    endcase
  endfunction

  logic                inc;
  logic [MAN_BITS+1:0] mant_rnd;
  logic                carry;
  logic                subnorm_promote;
  logic [EXP_BITS+1:0] exp_rnd;
  logic [MAN_BITS-1:0] mant_field;
  logic                overflow;
  logic                to_max;
  logic                inexact;
  logic [WIDTH-1:0]    res_fp;
  logic [Width-1:0]    res_boxed;

  always_comb begin
    inc             = round_up(rnd_mode_i, sign_i, mant_i[0], round_i, sticky_i);
    mant_rnd        = {1'b0, mant_i} + {{(MAN_BITS+1){1'b0}}, inc};
    carry           = mant_rnd[MAN_BITS+1];
    // A subnormal whose increment reaches the implicit bit is the smallest normal.
    subnorm_promote = (exp_i == '0) & mant_rnd[MAN_BITS];
    exp_rnd         = {1'b0, exp_i} + {{(EXP_BITS+1){1'b0}}, carry | subnorm_promote};
    mant_field      = carry ? '0 : mant_rnd[MAN_BITS-1:0];
    overflow        = (exp_rnd >= EXP_OVF);
    to_max          = (rnd_mode_i == RTZ) | ((rnd_mode_i == RDN) & ~sign_i) |
                      ((rnd_mode_i == RUP) & sign_i);
    inexact         = round_i | sticky_i | overflow;

    res_fp          = {sign_i, exp_rnd[EXP_BITS-1:0], mant_field};
    status_o        = '{NV: nv_i, DZ: dz_i, OF: overflow,
                        UF: (exp_i == '0) & inexact, NX: inexact};
    if (overflow) begin
      res_fp = to_max ? {sign_i, {(EXP_BITS-1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}}
                      : {sign_i, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
    end

    if (is_nan_i) begin
      res_fp   = CNAN[WIDTH-1:0];
      status_o = '{NV: nv_i, DZ: dz_i, OF: 1'b0, UF: 1'b0, NX: 1'b0};
    end else if (is_inf_i) begin
      res_fp   = {sign_i, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      status_o = '{NV: nv_i, DZ: dz_i, OF: 1'b0, UF: 1'b0, NX: 1'b0};
    end else if (is_zero_i) begin
      res_fp   = {sign_i, {(WIDTH-1){1'b0}}};
      status_o = '{NV: nv_i, DZ: dz_i, OF: 1'b0, UF: 1'b0, NX: 1'b0};
    end

    res_boxed              = '1;
    res_boxed[WIDTH-1:0]   = res_fp;
    result_o               = res_boxed;
  end

endmodule

// File: rtl/fpnew_value_encoder.sv
// Output encoder: combinational round/pack followed by NumPipeRegs handshake stages
// with flush; NumPipeRegs=0 gives a pure pass-through path.
module fpnew_value_encoder import fpnew_pkg::*; #(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned Width       = 64,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4,
  localparam int unsigned EXP_BITS   = exp_bits(FpFormat),
  localparam int unsigned MAN_BITS   = man_bits(FpFormat)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                sign_i,
  input  logic [EXP_BITS:0]   exp_i,
  input  logic [MAN_BITS:0]   mant_i,
  input  logic                round_i,
  input  logic                sticky_i,
  input  logic                is_nan_i,
  input  logic                is_inf_i,
  input  logic                is_zero_i,
  input  logic                nv_i,
  input  logic                dz_i,
  input  roundmode_e          rnd_mode_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output status_t             status_o,
  output logic [TagWidth-1:0] tag_o
);

  typedef struct packed {
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } stage_t;

  stage_t in_stage;

  fpnew_round_pack #(
    .FpFormat (FpFormat),
    .Width    (Width)
  ) u_round_pack (
    .sign_i     (sign_i),
    .exp_i      (exp_i),
    .mant_i     (mant_i),
    .round_i    (round_i),
    .sticky_i   (sticky_i),
    .is_nan_i   (is_nan_i),
    .is_inf_i   (is_inf_i),
    .is_zero_i  (is_zero_i),
    .nv_i       (nv_i),
    .dz_i       (dz_i),
    .rnd_mode_i (rnd_mode_i),
    .result_o   (in_stage.result),
    .status_o   (in_stage.status)
  );

  assign in_stage.tag = tag_i;

  if (NumPipeRegs == 0) begin : gen_comb
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign result_o    = in_stage.result;
    assign status_o    = in_stage.status;
    assign tag_o       = in_stage.tag;
  end else begin : gen_pipe
    logic [NumPipeRegs-1:0] valid_q;
    stage_t                 data_q       [NumPipeRegs];
    logic [NumPipeRegs-1:0] stage_ready;
    logic [NumPipeRegs-1:0] stage_in_vld;
    stage_t                 stage_in     [NumPipeRegs];

    // Ready ripples back from the output: a stage takes data if empty or draining.
    always_comb begin
      stage_ready                = '0;
      stage_ready[NumPipeRegs-1] = ~valid_q[NumPipeRegs-1] | out_ready_i;
      for (int i = NumPipeRegs - 2; i >= 0; i--) begin
        stage_ready[i] = ~valid_q[i] | stage_ready[i+1];
      end
    end

    always_comb begin
      stage_in_vld    = '0;
      stage_in_vld[0] = in_valid_i;
      stage_in[0]     = in_stage;
      for (int i = 1; i < NumPipeRegs; i++) begin
        stage_in_vld[i] = valid_q[i-1];
        stage_in[i]     = data_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int i = 0; i < NumPipeRegs; i++) data_q[i] <= '0;
      end else begin
        for (int i = 0; i < NumPipeRegs; i++) begin
          valid_q[i] <= ~flush_i & (stage_ready[i] ? stage_in_vld[i] : valid_q[i]);
          if (stage_ready[i] && stage_in_vld[i]) data_q[i] <= stage_in[i];
        end
      end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_q[NumPipeRegs-1];
    assign result_o    = data_q[NumPipeRegs-1].result;
    assign status_o    = data_q[NumPipeRegs-1].status;
    assign tag_o       = data_q[NumPipeRegs-1].tag;
  end

endmodule

// File: tb/tb_fpnew_value_encoder.sv
// Bench for fpnew_value_encoder (FP32, Width 64): one-stage and two-stage instances
// checked against an integer-encoding model through a scoreboard.
module tb_fpnew_value_encoder;
  import fpnew_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  st;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic [3:0]  tag;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst, flush1, flush2;
  logic in_valid1, in_valid2, in_ready1, in_ready2;
  logic out_valid1, out_valid2, out_ready1, out_ready2;
  logic sgn, rnd, stk, fnan, finf, fzero, fnv, fdz;
  logic [8:0]  expn;
  logic [23:0] mant;
  roundmode_e  rm;
  logic [3:0]  tag, tag1o, tag2o;
  logic [63:0] result1, result2;
  status_t     status1, status2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  sb_t q1[$];
  sb_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpnew_value_encoder #(.FpFormat(FP32), .Width(64), .NumPipeRegs(1), .TagWidth(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .sign_i(sgn), .exp_i(expn), .mant_i(mant), .round_i(rnd), .sticky_i(stk),
    .is_nan_i(fnan), .is_inf_i(finf), .is_zero_i(fzero), .nv_i(fnv), .dz_i(fdz),
    .rnd_mode_i(rm), .tag_i(tag), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .result_o(result1), .status_o(status1), .tag_o(tag1o));

  fpnew_value_encoder #(.FpFormat(FP32), .Width(64), .NumPipeRegs(2), .TagWidth(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .sign_i(sgn), .exp_i(expn), .mant_i(mant), .round_i(rnd), .sticky_i(stk),
    .is_nan_i(fnan), .is_inf_i(finf), .is_zero_i(fzero), .nv_i(fnv), .dz_i(fdz),
    .rnd_mode_i(rm), .tag_i(tag), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .result_o(result2), .status_o(status2), .tag_o(tag2o));

  // FP32 values are monotone in their bit encoding, so rounding is an integer
  // increment of the packed magnitude; overflow is reaching the infinity code.
  function automatic exp_t model(input logic s, input logic [8:0] e, input logic [23:0] m,
                                 input logic r, input logic k, input logic isnan,
                                 input logic isinf, input logic iszero, input logic nv,
                                 input logic dz, input roundmode_e mode);
    exp_t   o;
    longint mag;
    logic   up, nx;
    nx = r | k;
    case (mode)
      RNE:     up = (r && k) || (r && !k && m[0]);
      RDN:     up = nx && s;
      RUP:     up = nx && !s;
      RMM:     up = r;
      default: up = 1'b0;
    endcase
    if (e == 9'd0) mag = longint'(m);
    else           mag = (longint'(e) << 23) + longint'(m) - (longint'(1) << 23);
    mag  = mag + (up ? 1 : 0);
    o.st = {nv, dz, 3'b000};
    o.res = 64'hFFFFFFFF_00000000;
    if (isnan) o.res[31:0] = 32'h7FC00000;
    else if (isinf) o.res[31:0] = {s, 31'h7F800000};
    else if (iszero) o.res[31:0] = {s, 31'h0};
    else if (mag >= longint'(32'h7F800000)) begin
      if (mode == RTZ || (mode == RDN && !s) || (mode == RUP && s))
        o.res[31:0] = {s, 31'h7F7FFFFF};
      else
        o.res[31:0] = {s, 31'h7F800000};
      o.st[2:0] = {1'b1, e == 9'd0, 1'b1};
    end else begin
      o.res[31:0] = {s, mag[30:0]};
      o.st[2:0]   = {1'b0, (e == 9'd0) && nx, nx};
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic sb_t mk_entry();
    sb_t  e;
    exp_t x;
    x     = model(sgn, expn, mant, rnd, stk, fnan, finf, fzero, fnv, fdz, rm);
    e.res = x.res;
    e.st  = x.st;
    e.tag = tag;
    e.cyc = cyc;
    return e;
  endfunction

  // Single compare process for both instances.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) chk("u1_stale_valid", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          chk("u1_result", result1, e.res);
          chk("u1_status", {59'd0, status1}, {59'd0, e.st});
          chk("u1_tag", {60'd0, tag1o}, {60'd0, e.tag});
          chk("u1_latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (in_valid1 && in_ready1 && !flush1) q1.push_back(mk_entry());

      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) chk("u2_stale_valid", 64'd1, 64'd0);
        else begin
          e = q2.pop_front();
          chk("u2_result", result2, e.res);
          chk("u2_status", {59'd0, status2}, {59'd0, e.st});
          chk("u2_tag", {60'd0, tag2o}, {60'd0, e.tag});
        end
      end
      if (in_valid2 && in_ready2 && !flush2) q2.push_back(mk_entry());
      if (flush2) q2.delete();
    end
  end

  task automatic set_in(input logic s, input logic [8:0] e, input logic [23:0] m,
                        input logic r, input logic k, input logic isnan, input logic isinf,
                        input logic iszero, input logic nv, input logic dz,
                        input roundmode_e mode);
    sgn = s; expn = e; mant = m; rnd = r; stk = k;
    fnan = isnan; finf = isinf; fzero = iszero; fnv = nv; fdz = dz; rm = mode;
    tag = tag + 4'd1;
  endtask

  // Drive one vector into the one-stage instance and pin the model to a literal.
  task automatic send1(input string name, input logic s, input logic [8:0] e,
                       input logic [23:0] m, input logic r, input logic k, input logic isnan,
                       input logic isinf, input logic iszero, input logic nv, input logic dz,
                       input roundmode_e mode, input logic [31:0] lit, input logic [4:0] lst);
    exp_t x;
    @(posedge clk); #1;
    set_in(s, e, m, r, k, isnan, isinf, iszero, nv, dz, mode);
    in_valid1 = 1'b1;
    x = model(s, e, m, r, k, isnan, isinf, iszero, nv, dz, mode);
    chk({name, "_model_res"}, x.res, {32'hFFFFFFFF, lit});
    chk({name, "_model_st"}, {59'd0, x.st}, {59'd0, lst});
  endtask

  // Offer one vector to the two-stage instance and hold it until accepted.
  task automatic send2(input logic [8:0] e, input logic [23:0] m, input logic r);
    bit ok;
    set_in(1'b0, e, m, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RNE);
    in_valid2 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("u2_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush1 = 1'b0; flush2 = 1'b0;
    in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    tag = 4'd0;
    set_in(1'b0, 9'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RNE);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
    chk("rst_result1", result1, 64'd0);
    chk("rst_status1", {59'd0, status1}, 64'd0);
    chk("rst_tag1", {60'd0, tag1o}, 64'd0);
    chk("rst_in_ready1", {63'd0, in_ready1}, 64'd1);
    chk("rst_out_valid2", {63'd0, out_valid2}, 64'd0);
    chk("rst_result2", result2, 64'd0);
    chk("rst_in_ready2", {63'd0, in_ready2}, 64'd1);

    //     name             s  exp     mant        r  k  nan inf zero nv dz mode lit            st
    send1("one",           0, 9'd127, 24'h800000, 0, 0, 0, 0, 0, 0, 0, RNE, 32'h3F800000, 5'h00);
    send1("carry",         0, 9'd127, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, RNE, 32'h40000000, 5'h01);
    send1("ovf_rne",       0, 9'd254, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, RNE, 32'h7F800000, 5'h05);
    send1("big_rtz",       0, 9'd254, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, RTZ, 32'h7F7FFFFF, 5'h01);
    send1("nan",           1, 9'd127, 24'h800000, 0, 0, 1, 0, 0, 1, 0, RNE, 32'h7FC00000, 5'h10);
    send1("sub_min",       0, 9'd0,   24'h000001, 1, 1, 0, 0, 0, 0, 0, RNE, 32'h00000002, 5'h03);
    send1("sub_promote",   0, 9'd0,   24'h7FFFFF, 1, 0, 0, 0, 0, 0, 0, RNE, 32'h00800000, 5'h03);
    send1("ovf_rdn_neg",   1, 9'd254, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, RDN, 32'hFF800000, 5'h05);
    send1("rup_neg",       1, 9'd254, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, RUP, 32'hFF7FFFFF, 5'h01);
    send1("ovf_exp_rtz",   0, 9'd255, 24'h800000, 0, 0, 0, 0, 0, 0, 0, RTZ, 32'h7F7FFFFF, 5'h05);
    send1("rmm_tie",       0, 9'd100, 24'h800001, 1, 0, 0, 0, 0, 0, 0, RMM, 32'h32000002, 5'h01);
    send1("rne_tie_even",  0, 9'd100, 24'h800002, 1, 0, 0, 0, 0, 0, 0, RNE, 32'h32000002, 5'h01);
    send1("inf_neg",       1, 9'd127, 24'hFFFFFF, 1, 1, 0, 1, 0, 0, 1, RNE, 32'hFF800000, 5'h08);
    send1("zero_neg",      1, 9'd0,   24'h000000, 0, 0, 0, 0, 1, 0, 0, RNE, 32'h80000000, 5'h00);
    send1("nan_over_inf",  0, 9'd3,   24'h800000, 0, 0, 1, 1, 0, 0, 0, RNE, 32'h7FC00000, 5'h00);
    send1("rup_pos",       0, 9'd130, 24'h800000, 0, 1, 0, 0, 0, 0, 0, RUP, 32'h41000001, 5'h01);
    @(posedge clk); #1 in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    chk("u1_drained", 64'(q1.size()), 64'd0);

    // Backpressure on the two-stage instance: 4 stalled cycles, 3 offered inputs.
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    fork
      begin
        send2(9'd127, 24'h800000, 1'b0);
        send2(9'd128, 24'hC00000, 1'b1);
        send2(9'd129, 24'hA00001, 1'b1);
        in_valid2 = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("u2_ready_after_1", {63'd0, in_ready2}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("u2_ready_after_2", {63'd0, in_ready2}, 64'd0);
        repeat (2) @(posedge clk);
        #1 out_ready2 = 1'b1;
      end
    join
    for (int k = 0; k < 20; k++) begin
      if (q2.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("u2_drained", 64'(q2.size()), 64'd0);

    // Flush with two items in flight and a third offered in the flush cycle.
    @(posedge clk); #1;
    set_in(0, 9'd140, 24'h900000, 0, 0, 0, 0, 0, 0, 0, RNE);
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    set_in(1, 9'd141, 24'h900000, 1, 0, 0, 0, 0, 0, 0, RNE);
    @(posedge clk); #1;
    set_in(0, 9'd142, 24'h900000, 0, 1, 0, 0, 0, 0, 0, RNE);
    flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("u2_valid_after_flush", {63'd0, out_valid2}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("u2_no_stale_after_flush", {63'd0, out_valid2}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
